// File: rtl/arbiter_wrr_hs.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_wrr_hs
// Description : Handshake-aware weighted round-robin arbiter with owner lock.
//               Weight credits are spent per accepted beat (o_gnt_valid &
//               i_ready & i_req[owner]), so downstream stalls never cost a
//               client bandwidth. The edge that accepts an owner's final
//               beat also loads the next owner (no bubble between owners).
//               Optional starvation guard: macro ARB_WRR_STARVE_EN.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_req        per-client request (level)
//   i_lock       per-client lock, only the owner's bit is honoured
//   i_weight     packed weights, client 0 in LSBs; W gives W+1 beats/turn
//   i_ready      downstream accepts the current beat
//   o_gnt        one-hot registered grant
//   o_gnt_valid  OR of o_gnt
//   o_gnt_idx    owner index (also the round-robin pointer)
//   o_credit     remaining extra beats for the owner
//   o_starved    per-client starvation flags (0 without ARB_WRR_STARVE_EN)
// ============================================================================
module arbiter_wrr_hs #(
  parameter int NUM_CLIENTS  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int STARVE_WIDTH = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CLIENTS-1:0]              i_req,
  input  logic [NUM_CLIENTS-1:0]              i_lock,
  input  logic [NUM_CLIENTS*WEIGHT_WIDTH-1:0] i_weight,
  input  logic                                i_ready,
  output logic [NUM_CLIENTS-1:0]              o_gnt,
  output logic                                o_gnt_valid,
  output logic [$clog2(NUM_CLIENTS)-1:0]      o_gnt_idx,
  output logic [WEIGHT_WIDTH-1:0]             o_credit,
  output logic [NUM_CLIENTS-1:0]              o_starved
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CLIENTS-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [WEIGHT_WIDTH-1:0] weight_w [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]  starved_w;
  logic                    starve_any_w;
  logic [NUM_CLIENTS-1:0]  search_mask_w;
  logic [IDX_W-1:0]        pick_w;
  logic                    owner_req_w;
  logic                    accept_w;
  logic                    release_w;

  if (NUM_CLIENTS < 2 || STARVE_LIMIT >= (1 << STARVE_WIDTH)) begin : g_param_check
    $error("arbiter_wrr_hs: illegal NUM_CLIENTS or STARVE_LIMIT");
  end

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_weight
    assign weight_w[g] = i_weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  // Scan ptr+1 .. ptr (owner last). Iterating from the far end means the
  // last hit written is the nearest requester in round-robin order.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] mask,
                                               input logic [IDX_W-1:0]       ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand_idx;
    int               cand;
    pick = ptr;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      cand_idx = IDX_W'(cand);
      if (mask[cand_idx]) pick = cand_idx;
    end
    return pick;
  endfunction

`ifdef ARB_WRR_STARVE_EN
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_starve
    logic [STARVE_WIDTH-1:0] wait_q;
    // Cleared on the edge that grants the client, so the flag drops
    // together with the grant appearing.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_q <= '0;
      end else if (!i_req[g] || gnt_d[g]) begin
        wait_q <= '0;
      end else if (wait_q != '1) begin
        wait_q <= wait_q + STARVE_WIDTH'(1);
      end
    end
    assign starved_w[g] = (wait_q >= STARVE_WIDTH'(STARVE_LIMIT));
  end
  // A flag whose client just dropped its request must not steer the search.
  assign starve_any_w = |(starved_w & i_req);
`else
  assign starved_w    = '0;
  assign starve_any_w = 1'b0;
`endif

  always_comb begin
    owner_req_w   = i_req[ptr_q];
    accept_w      = (state_q == ST_GRANT) && i_ready && owner_req_w;
    release_w     = (state_q == ST_GRANT) &&
                    (!owner_req_w ||
                     (accept_w && !i_lock[ptr_q] && ((credit_q == '0) || starve_any_w)));
    search_mask_w = starve_any_w ? (starved_w & i_req) : i_req;
    pick_w        = rr_pick(search_mask_w, ptr_q);

    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;

    if ((state_q == ST_IDLE) || release_w) begin
      if (|i_req) begin
        state_d         = ST_GRANT;
        gnt_d           = '0;
        gnt_d[pick_w]   = 1'b1;
        ptr_d           = pick_w;
        credit_d        = weight_w[pick_w];
      end else begin
        // Pointer is deliberately kept so fairness survives idle periods.
        state_d  = ST_IDLE;
        gnt_d    = '0;
        credit_d = '0;
      end
    end else if (accept_w && (credit_q != '0)) begin
      // Locked owners also drain credit, saturating at zero.
      credit_d = credit_q - WEIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      ptr_q    <= IDX_W'(NUM_CLIENTS - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_valid = |gnt_q;
  assign o_gnt_idx   = ptr_q;
  assign o_credit    = credit_q;
  assign o_starved   = starved_w;

endmodule
`default_nettype wire
